// File: rtl/logic_pipe_checked_pkg.sv
// logic_pipe_checked_pkg
// Shared definitions for the checked bitwise-logic pipeline:
//   - 3-bit function-select encodings OP_AND .. OP_NIMP
//   - default operand width and mismatch-counter width
//   - number of defined functions (every 3-bit encoding is used)
package logic_pipe_checked_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;
    localparam int NUM_OPS       = 8;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_IMP  = 3'd6;
    localparam logic [2:0] OP_NIMP = 3'd7;

endpackage

// File: rtl/nor_logic_slice.sv
// nor_logic_slice
// One bit of the gate-level result path, built exclusively from NOR gates.
// All eight functions are formed, then the one named by op is picked by a
// NOR-only AND-OR selector.
// Ports:
//   a, b : operand bits
//   op   : function select (OP_* encodings)
//   y    : selected function of a and b
module nor_logic_slice
    import logic_pipe_checked_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    output logic       y
);

    logic na, nb;
    logic nor_ab, or_ab, and_ab, nand_ab;
    logic xor_ab, xnor_ab, nimp_ab, imp_ab;
    logic [2:0] nop;
    logic [NUM_OPS-1:0] nf;
    logic [NUM_OPS-1:0] t;
    logic sel_n;

    // Every gate below is a NOR; single-input NORs act as inverters.
    assign na      = ~(a | a);
    assign nb      = ~(b | b);
    assign nor_ab  = ~(a | b);
    assign or_ab   = ~(nor_ab | nor_ab);
    assign and_ab  = ~(na | nb);
    assign nand_ab = ~(and_ab | and_ab);
    // a==b is (a&b)|(~a&~b); NOR of those two terms gives XOR.
    assign xor_ab  = ~(and_ab | nor_ab);
    assign xnor_ab = ~(xor_ab | xor_ab);
    assign nimp_ab = ~(na | b);
    assign imp_ab  = ~(nimp_ab | nimp_ab);
    assign nop     = ~(op | op);

    // The selector needs the complement of each function, since a term is
    // NOR(~f, op-literal mismatches).
    assign nf[OP_AND]  = nand_ab;
    assign nf[OP_OR]   = nor_ab;
    assign nf[OP_NAND] = and_ab;
    assign nf[OP_NOR]  = or_ab;
    assign nf[OP_XOR]  = xnor_ab;
    assign nf[OP_XNOR] = xor_ab;
    assign nf[OP_IMP]  = nimp_ab;
    assign nf[OP_NIMP] = imp_ab;

    // Term k is high only when op==k and function k is 1. Each op input to
    // the NOR must be 0 on a match, so the true bit is fed where k has a 0
    // and the inverted bit where k has a 1.
    for (genvar k = 0; k < NUM_OPS; k++) begin : g_term
        localparam logic [2:0] K = 3'(k);
        assign t[k] = ~(nf[k]
                        | (K[2] ? nop[2] : op[2])
                        | (K[1] ? nop[1] : op[1])
                        | (K[0] ? nop[0] : op[0]));
    end

    assign sel_n = ~(|t);
    assign y     = ~(sel_n | sel_n);

endmodule

// File: rtl/logic_pipe_checked.sv
// logic_pipe_checked
// Two-stage valid/ready pipeline computing a bitwise function of a and b.
// The result is produced twice from the S1 registers: once by a NOR-only
// gate network (r_g) and once by a behavioural expression (r_e). s carries
// r_e; any disagreement sets a sticky flag and bumps a saturating counter.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : upstream handshake for a, b, op
//   a, b, op             : operands and function select
//   out_valid, out_ready : downstream handshake for s
//   s                    : registered result
//   clr_err              : synchronous clear of mismatch / err_count
//   mismatch, err_count  : sticky disagreement flag and saturating count
module logic_pipe_checked
    import logic_pipe_checked_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    input  logic             clr_err,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_e;
    logic             s2_adv;
    logic             s1_adv;
    logic             disagree;

    // A stage may move whenever the stage downstream of it is empty or
    // emptying this cycle. in_ready is therefore combinational from
    // out_ready, and held low while in reset.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign disagree = s2_adv && s1_valid && (r_g != r_e);

    // Gate-level result: one NOR-only slice per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        nor_logic_slice u_slice (
            .a  (s1_a[i]),
            .b  (s1_b[i]),
            .op (s1_op),
            .y  (r_g[i])
        );
    end

    // Behavioural result; all eight encodings are listed so there is no
    // fall-through value in normal operation.
    always_comb begin
        r_e = '0;
        case (s1_op)
            OP_AND:  r_e = s1_a & s1_b;
            OP_OR:   r_e = s1_a | s1_b;
            OP_NAND: r_e = ~(s1_a & s1_b);
            OP_NOR:  r_e = ~(s1_a | s1_b);
            OP_XOR:  r_e = s1_a ^ s1_b;
            OP_XNOR: r_e = ~(s1_a ^ s1_b);
            OP_IMP:  r_e = ~s1_a | s1_b;
            OP_NIMP: r_e = s1_a & ~s1_b;
        endcase
    end

    // S1: operand registers only load on an actual transfer, so they hold
    // steady while the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    // S2: out_valid follows S1 whenever S2 may advance, so it drops on the
    // same edge as the last output transfer when S1 is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s <= r_e;
            end
        end
    end

    // Error state: a clear that lands on a new disagreement leaves exactly
    // that one disagreement recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch  <= 1'b0;
            err_count <= '0;
        end else if (clr_err) begin
            mismatch  <= disagree;
            err_count <= disagree ? CNT_W'(1) : '0;
        end else if (disagree) begin
            mismatch <= 1'b1;
            if (err_count != CNT_MAX) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/logic_pipe_checked.md
LOGIC_PIPE_CHECKED -- requirements
Module: logic_pipe_checked

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 Parameter CNT_W, default 8: width of the mismatch counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: upstream presents a, b, op.
REQ-006 Port in_ready, output, 1: block accepts the operand when high; a transfer occurs when in_valid && in_ready.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH: operand B.
REQ-009 Port op, input, 3: function select; 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 IMP (~a|b), 7 NIMP (a&~b).
REQ-010 Port out_valid, output, 1: s holds a valid result.
REQ-011 Port out_ready, input, 1: downstream accepts the result; a transfer occurs when out_valid && out_ready.
REQ-012 Port s, output, WIDTH: registered bitwise result.
REQ-013 Port clr_err, input, 1: synchronous clear of the error state.
REQ-014 Port mismatch, output, 1: sticky flag; gate-level and expression results have disagreed.
REQ-015 Port err_count, output, CNT_W: saturating count of disagreeing results.

Function
REQ-016 Two register stages: S1 captures a, b, op; S2 captures the result and the compare outcome. Latency from input transfer to out_valid is 2 cycles with no stall.
REQ-017 S2 advances (s2_adv) when !out_valid || out_ready. S1 advances when !s1_valid || s2_adv. in_ready = !s1_valid || s2_adv, which is a combinational path from out_ready.
REQ-018 Throughput is one result per cycle while out_ready stays high. Under stall, no data is lost or duplicated, and s, a, b and op stay stable in their registers.
REQ-019 Every result is computed twice from the S1 registers:
  - R_g, by a structural NOR-only network;
  - R_e, by a behavioural expression.
REQ-020 s is loaded with R_e.
REQ-021 When S2 loads and R_g != R_e (any bit):
  - mismatch is set to 1 and stays set until cleared;
  - err_count increments by 1 and saturates at 2^CNT_W-1 with no wrap.
REQ-022 clr_err zeroes mismatch and err_count on the next edge. If clr_err coincides with a new mismatch, the result is mismatch=1 and err_count=1.
REQ-023 An undefined op value is impossible: all 8 encodings are defined, and no default/X path exists.
REQ-024 When S1 is empty and S2 is drained, out_valid falls in the same edge as the final output transfer.

Reset
REQ-025 On rst_n low, asynchronously: s1_valid=0, out_valid=0, s=0, mismatch=0, err_count=0.
REQ-026 While rst_n is low, in_ready=0.
REQ-027 Reset mid-operation discards all in-flight data, and no result is emitted afterwards.
REQ-028 After rst_n is deasserted, in_ready=1 starting from the first edge.

Structure
REQ-029 A shared package holds:
  - the op encodings OP_AND..OP_NIMP as 3-bit constants;
  - the default values of WIDTH and CNT_W.
REQ-030 One sub-module, nor_logic_slice, is a 1-bit NOR-only implementation of all 8 ops, selected by op. The top instantiates it WIDTH times to form R_g.

Verification
REQ-031 WIDTH=8, out_ready=1, op=6, a=8'hF0, b=8'h3C -> s=8'h3F with out_valid exactly 2 cycles after the transfer; mismatch=0.
REQ-032 Sweep all 8 ops for a=8'hA5, b=8'h0F -> results in order: 05, AF, FA, 50, AA, 55, 5F, A0.
REQ-033 Back-to-back stream of 4 operands, out_ready held low for 3 cycles mid-stream -> all 4 results emerge in order; in_ready drops only while S1 and S2 are both full.
REQ-034 Force one R_g bit wrong for 3 results with CNT_W=2 -> mismatch=1, err_count=3 and then held at 3; pulse clr_err -> 0 and 0.
REQ-035 Assert rst_n=0 asynchronously mid-clock with 2 results in flight -> out_valid=0 and s=0 immediately; no stale result after release.
REQ-036 WIDTH=1, exhaustive over a, b, op (32 cases) -> s matches the truth table for each op, including IMP: 1,1,0,1 for (a,b) = 00, 01, 10, 11.
